// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution layer sequencer.
// Holds the sequencer state encoding and the per-filter weight/bias footprint.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SWAP = 3'd2,
    CONV = 3'd3,
    NEXT = 3'd4,
    DONE = 3'd5
  } seq_state_e;

  // Weights plus biases: two words per kernel tap, shown for the default 3x3 kernel.
  localparam int KERNEL_WORDS = 3 * 3 * 2;

  function automatic int kernel_words(input int ksize);
    return ksize * ksize * 2;
  endfunction

endpackage

// File: rtl/conv_perf_counter.sv
// Busy-cycle counter for a sequencer run: clears on run acceptance, counts while busy.
// Holds its value once the run finishes or is aborted.
module conv_perf_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (inc_i) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/conv_layer_sequencer.sv
// Steps a conv layer through load/swap/convolve per filter, driving weight and output bases.
// Optional busy-cycle counter port perf_cycles_o is present when CONV_SEQ_PERF_EN is defined.
module conv_layer_sequencer
  import conv_pkg::*;
#(
  parameter int KernelSize    = 3,
  parameter int MatrixSize    = 3,
  parameter int AddrSize      = 10,
  parameter int ConvCountSize = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [ConvCountSize-1:0] filter_count_i,
  output logic                     load_req_o,
  input  logic                     load_done_i,
  output logic                     update_o,
  output logic                     conv_start_o,
  input  logic                     conv_done_i,
  output logic [AddrSize-1:0]      weight_base_o,
  output logic [AddrSize-1:0]      out_base_o,
  output logic [ConvCountSize-1:0] filter_idx_o,
  output logic                     busy_o,
  output logic                     done_o
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_cycles_o
`endif
);

  localparam int KWords = kernel_words(KernelSize);
  localparam int MWords = MatrixSize * MatrixSize;
  localparam logic [ConvCountSize-1:0] IdxOne = {{(ConvCountSize-1){1'b0}}, 1'b1};

  seq_state_e                r_state, w_state_d;
  logic [ConvCountSize-1:0]  r_count, w_count_d;
  logic [ConvCountSize-1:0]  r_idx, w_idx_d, w_idx_inc;
  logic [AddrSize-1:0]       r_wbase, r_obase;
  logic                      r_conv_start, r_zero_done;
  logic                      w_base_upd, w_zero_done, w_accept;
  logic [31:0]               w_wbase_full, w_obase_full;

  assign w_idx_inc    = r_idx + IdxOne;
  assign w_wbase_full = 32'(w_idx_d) * 32'(KWords);
  assign w_obase_full = 32'(w_idx_d) * 32'(MWords);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_idx        <= '0;
      r_wbase      <= '0;
      r_obase      <= '0;
      r_conv_start <= 1'b0;
      r_zero_done  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_count      <= w_count_d;
      r_idx        <= w_idx_d;
      r_conv_start <= (r_state == SWAP) && !abort_i;
      r_zero_done  <= w_zero_done;
      if (w_base_upd) begin
        r_wbase <= w_wbase_full[AddrSize-1:0];
        r_obase <= w_obase_full[AddrSize-1:0];
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_count_d   = r_count;
    w_idx_d     = r_idx;
    w_base_upd  = 1'b0;
    w_zero_done = 1'b0;
    w_accept    = 1'b0;
    load_req_o  = (r_state == LOAD);
    update_o    = (r_state == SWAP);
    busy_o      = (r_state != IDLE);

    // Abort beats any handshake seen in the same cycle; bases keep their last value.
    if (r_state != IDLE && abort_i) begin
      w_state_d = IDLE;
      w_idx_d   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            w_accept = 1'b1;
            if (filter_count_i != '0) begin
              w_count_d  = filter_count_i;
              w_idx_d    = '0;
              w_base_upd = 1'b1;
              w_state_d  = LOAD;
            end else begin
              w_zero_done = 1'b1;
            end
          end
        end
        LOAD:    if (load_done_i) w_state_d = SWAP;
        SWAP:    w_state_d = CONV;
        CONV:    if (conv_done_i) w_state_d = NEXT;
        NEXT: begin
          w_idx_d    = w_idx_inc;
          w_base_upd = 1'b1;
          w_state_d  = (w_idx_inc == r_count) ? DONE : LOAD;
        end
        DONE:    w_state_d = IDLE;
        default: w_state_d = IDLE;
      endcase
    end
  end

  assign conv_start_o  = r_conv_start;
  assign done_o        = (r_state == DONE) || r_zero_done;
  assign weight_base_o = r_wbase;
  assign out_base_o    = r_obase;
  assign filter_idx_o  = r_idx;

`ifdef CONV_SEQ_PERF_EN
  conv_perf_counter u_perf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (w_accept),
    .inc_i   (busy_o),
    .count_o (perf_cycles_o)
  );
`endif

endmodule
